// File: rtl/pc_progmem_seq.sv
// Program counter with loadable program RAM, LOAD/RUN/HALT sequencer,
// registered fetch stage and a hardware return stack.
module pc_progmem_seq #(
  parameter int INSTR_W     = 16,
  parameter int PC_W        = 5,
  parameter int OPC_LSB     = 2,
  parameter int STACK_DEPTH = 4,
  parameter bit WRAP_EN     = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_ce,
  input  logic               i_prog_we,
  input  logic [PC_W-1:0]    i_prog_waddr,
  input  logic [INSTR_W-1:0] i_prog_wdata,
  input  logic               i_start,
  input  logic               i_halt,
  input  logic               i_jump,
  input  logic               i_call,
  input  logic               i_ret,
  input  logic [PC_W-1:0]    i_target,
  output logic [PC_W-1:0]    o_pc_addr,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_instr_valid,
  output logic [3:0]         o_operation_code_2_id,
  output logic               o_running,
  output logic               o_halted,
  output logic               o_stack_err
);

  localparam int DEPTH = 2 ** PC_W;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int STK_N = 2 ** SP_W;

  localparam logic [PC_W-1:0] LAST_PC = {PC_W{1'b1}};
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [INSTR_W-1:0] mem_q [DEPTH];
  logic [PC_W-1:0]    stk_q [STK_N];

  logic [PC_W-1:0]    fpc_q, fpc_d;
  logic [PC_W-1:0]    pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               valid_q, valid_d;
  logic [SP_W-1:0]    sp_q, sp_d;
  logic               err_q, err_d;

  logic               fetch_en;
  logic               push;
  logic               ram_we;
  logic               stk_empty;
  logic               stk_full;
  logic               redirect;
  logic               stk_fault;
  logic [SP_W-1:0]    top_idx;

  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SP_FULL);
  assign top_idx   = sp_q - SP_ONE;
  assign redirect  = i_ret | i_call | i_jump;

  // Return beats call, so a full stack only matters when no return is pending.
  assign stk_fault = (i_ret & stk_empty) |
                     (~i_ret & i_call & stk_full);

  always_comb begin
    state_d  = state_q;
    fpc_d    = fpc_q;
    valid_d  = valid_q;
    sp_d     = sp_q;
    err_d    = err_q;
    fetch_en = 1'b0;
    push     = 1'b0;
    ram_we   = 1'b0;
    unique case (state_q)
      S_LOAD: begin
        ram_we = i_prog_we;
        if (i_start) begin
          state_d = S_RUN;
          fpc_d   = '0;
        end
      end
      S_RUN: begin
        if (i_ce) begin
          if (i_halt) begin
            state_d = S_HALT;
            valid_d = 1'b0;
          end else if (stk_fault) begin
            err_d   = 1'b1;
            state_d = S_HALT;
            valid_d = 1'b0;
          end else begin
            fetch_en = 1'b1;
            valid_d  = ~redirect;
            if (i_ret) begin
              sp_d  = top_idx;
              fpc_d = stk_q[top_idx];
            end else if (i_call) begin
              push  = 1'b1;
              sp_d  = sp_q + SP_ONE;
              fpc_d = i_target;
            end else if (i_jump) begin
              fpc_d = i_target;
            end else begin
              fpc_d = fpc_q + PC_ONE;
              if (!WRAP_EN && fpc_q == LAST_PC) begin
                state_d = S_HALT;
              end
            end
          end
        end
      end
      S_HALT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_LOAD;
      fpc_q   <= '0;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fpc_q   <= fpc_d;
      valid_q <= valid_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      if (fetch_en) begin
        instr_q <= mem_q[fpc_q];
        pc_q    <= fpc_q;
      end
    end
  end

  // Program RAM and stack storage carry no reset; contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (ram_we && !i_rst) begin
      mem_q[i_prog_waddr] <= i_prog_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      stk_q[sp_q] <= pc_q + PC_ONE;
    end
  end

  assign o_pc_addr             = pc_q;
  assign o_instr               = instr_q;
  assign o_instr_valid         = valid_q;
  assign o_operation_code_2_id = instr_q[OPC_LSB+3:OPC_LSB];
  assign o_running             = (state_q == S_RUN);
  assign o_halted              = (state_q == S_HALT);
  assign o_stack_err           = err_q;

endmodule

// File: tb/tb_pc_progmem_seq.sv
// Bench for pc_progmem_seq: directed vector table, hand sequences,
// end-of-memory checks on 3-bit instances and a randomized model run.
module tb_pc_progmem_seq;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        prog_we;
  logic [4:0]  waddr;
  logic [15:0] wdata;
  logic        start;
  logic        halt;
  logic        jump;
  logic        call;
  logic        ret;
  logic [4:0]  target;

  logic [4:0]  pc_addr;
  logic [15:0] instr;
  logic        ivalid;
  logic [3:0]  opc;
  logic        running;
  logic        halted;
  logic        serr;

  logic [2:0]  s0_pc, s1_pc;
  logic [15:0] s0_instr, s1_instr;
  logic        s0_v, s1_v;
  logic [3:0]  s0_opc, s1_opc;
  logic        s0_run, s1_run;
  logic        s0_hlt, s1_hlt;
  logic        s0_err, s1_err;

  int checks = 0;
  int errors = 0;

  pc_progmem_seq dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .i_prog_we(prog_we), .i_prog_waddr(waddr), .i_prog_wdata(wdata),
    .i_start(start), .i_halt(halt), .i_jump(jump), .i_call(call),
    .i_ret(ret), .i_target(target),
    .o_pc_addr(pc_addr), .o_instr(instr), .o_instr_valid(ivalid),
    .o_operation_code_2_id(opc), .o_running(running),
    .o_halted(halted), .o_stack_err(serr)
  );

  pc_progmem_seq #(.PC_W(3), .WRAP_EN(1'b0)) dut_nowrap (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .i_prog_we(prog_we), .i_prog_waddr(waddr[2:0]), .i_prog_wdata(wdata),
    .i_start(start), .i_halt(halt), .i_jump(jump), .i_call(call),
    .i_ret(ret), .i_target(target[2:0]),
    .o_pc_addr(s0_pc), .o_instr(s0_instr), .o_instr_valid(s0_v),
    .o_operation_code_2_id(s0_opc), .o_running(s0_run),
    .o_halted(s0_hlt), .o_stack_err(s0_err)
  );

  pc_progmem_seq #(.PC_W(3), .WRAP_EN(1'b1)) dut_wrap (
    .i_clk(clk), .i_rst(rst), .i_ce(ce),
    .i_prog_we(prog_we), .i_prog_waddr(waddr[2:0]), .i_prog_wdata(wdata),
    .i_start(start), .i_halt(halt), .i_jump(jump), .i_call(call),
    .i_ret(ret), .i_target(target[2:0]),
    .o_pc_addr(s1_pc), .o_instr(s1_instr), .o_instr_valid(s1_v),
    .o_operation_code_2_id(s1_opc), .o_running(s1_run),
    .o_halted(s1_hlt), .o_stack_err(s1_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         start;
    bit         ce;
    bit         jump;
    bit         call;
    bit         ret;
    logic [4:0] tgt;
    bit         ev;
    logic [4:0] epc;
    bit         ezero;
  } vec_t;

  vec_t        tv[22];
  logic [15:0] prog[32];
  logic [15:0] eom[8];

  function automatic vec_t mk(bit s, bit c, bit j, bit cl, bit r,
                              int t, bit ev, int epc, bit ez);
    vec_t v;
    v.start = s; v.ce = c; v.jump = j; v.call = cl; v.ret = r;
    v.tgt = 5'(t); v.ev = ev; v.epc = 5'(epc); v.ezero = ez;
    return v;
  endfunction

  function automatic logic [31:0] ep(bit e, bit h, bit r, bit v,
                                     logic [4:0] pc, logic [15:0] ins);
    logic [3:0] op;
    op = 4'((ins >> 2) & 16'hF);
    return {3'b0, e, h, r, v, op, pc, ins};
  endfunction

  function automatic logic [31:0] pack_main();
    return {3'b0, serr, halted, running, ivalid, opc, pc_addr, instr};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    prog_we = 0; waddr = 0; wdata = 0; start = 0; halt = 0;
    jump = 0; call = 0; ret = 0; target = 0; ce = 1;
  endtask

  task automatic do_reset(string name);
    rst = 1'b1;
    #1;
    chk(name, pack_main(), ep(0, 0, 0, 0, 5'd0, 16'h0));
    tick();
    rst = 1'b0;
  endtask

  // Behavioural reference: mode 0 = load, 1 = run, 2 = halt.
  int          m_mode;
  int          m_fpc;
  int          m_stk[$];
  logic [4:0]  m_pc;
  logic [15:0] m_instr;
  bit          m_valid;
  bit          m_err;
  logic [15:0] m_mem[32];

  function automatic void m_reset();
    m_mode = 0; m_fpc = 0; m_stk.delete();
    m_pc = 0; m_instr = 0; m_valid = 0; m_err = 0;
  endfunction

  function automatic void m_step();
    int nxt;
    int ret_addr;
    case (m_mode)
      0: begin
        if (prog_we) m_mem[waddr] = wdata;
        if (start) begin
          m_mode = 1;
          m_fpc  = 0;
        end
      end
      1: if (ce) begin
        if (halt) begin
          m_mode = 2; m_valid = 0;
        end else if ((ret && m_stk.size() == 0) ||
                     (!ret && call && m_stk.size() == 4)) begin
          m_err = 1; m_mode = 2; m_valid = 0;
        end else begin
          ret_addr = (int'(m_pc) + 1) % 32;
          m_valid = 0;
          if (ret) nxt = m_stk.pop_back();
          else if (call) begin
            m_stk.push_back(ret_addr);
            nxt = int'(target);
          end else if (jump) nxt = int'(target);
          else begin
            nxt = (m_fpc + 1) % 32;
            m_valid = 1;
          end
          m_pc    = 5'(m_fpc);
          m_instr = m_mem[m_fpc];
          m_fpc   = nxt;
        end
      end
      default: m_valid = 0;
    endcase
  endfunction

  function automatic logic [31:0] m_pack();
    return ep(m_err, m_mode == 2, m_mode == 1, m_valid, m_pc, m_instr);
  endfunction

  task automatic rnd_tick();
    @(posedge clk);
    m_step();
    #1;
    chk("rnd", pack_main(), m_pack());
  endtask

  task automatic rnd_reset();
    clear_in();
    rst = 1'b1;
    #1;
    m_reset();
    chk("rnd_reset", pack_main(), m_pack());
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rnd_load();
    for (int a = 0; a < 32; a++) begin
      prog_we = 1; waddr = 5'(a); wdata = 16'($urandom);
      rnd_tick();
    end
    prog_we = 0;
  endtask

  initial begin
    int hcnt;
    int r;
    rst = 1'b1;
    clear_in();
    prog[0] = 16'h0003; prog[1] = 16'h03EB;
    prog[2] = 16'h000F; prog[3] = 16'h0067;
    for (int i = 4; i < 32; i++) prog[i] = 16'(i * 257) ^ 16'h5A00;
    for (int i = 0; i < 8; i++) eom[i] = 16'hA000 | 16'(i * 17);

    #2;
    chk("por", pack_main(), ep(0, 0, 0, 0, 5'd0, 16'h0));
    tick();
    rst = 1'b0;

    for (int a = 0; a < 32; a++) begin
      prog_we = 1; waddr = 5'(a); wdata = prog[a];
      tick();
    end
    prog_we = 0;

    tv[0]  = mk(1, 1, 0, 0, 0, 0,  0, 0,  1);
    tv[1]  = mk(0, 1, 0, 0, 0, 0,  1, 0,  0);
    tv[2]  = mk(0, 1, 0, 0, 0, 0,  1, 1,  0);
    tv[3]  = mk(0, 1, 0, 0, 0, 0,  1, 2,  0);
    tv[4]  = mk(0, 1, 0, 0, 0, 0,  1, 3,  0);
    tv[5]  = mk(0, 1, 0, 0, 0, 0,  1, 4,  0);
    tv[6]  = mk(0, 1, 0, 1, 0, 20, 0, 5,  0);
    tv[7]  = mk(0, 1, 0, 0, 0, 0,  1, 20, 0);
    tv[8]  = mk(0, 1, 0, 0, 0, 0,  1, 21, 0);
    tv[9]  = mk(0, 1, 0, 0, 1, 0,  0, 22, 0);
    tv[10] = mk(0, 1, 0, 0, 0, 0,  1, 5,  0);
    tv[11] = mk(0, 1, 0, 0, 0, 0,  1, 6,  0);
    tv[12] = mk(0, 1, 1, 0, 0, 2,  0, 7,  0);
    tv[13] = mk(0, 1, 0, 0, 0, 0,  1, 2,  0);
    tv[14] = mk(0, 1, 1, 0, 0, 10, 0, 3,  0);
    tv[15] = mk(0, 1, 0, 0, 0, 0,  1, 10, 0);
    tv[16] = mk(0, 1, 0, 0, 0, 0,  1, 11, 0);
    tv[17] = mk(0, 0, 0, 0, 0, 0,  1, 11, 0);
    tv[18] = mk(0, 0, 1, 0, 0, 0,  1, 11, 0);
    tv[19] = mk(0, 0, 0, 0, 0, 0,  1, 11, 0);
    tv[20] = mk(0, 1, 0, 0, 0, 0,  1, 12, 0);
    tv[21] = mk(0, 1, 0, 0, 0, 0,  1, 13, 0);

    for (int i = 0; i < 22; i++) begin
      start = tv[i].start; ce = tv[i].ce; jump = tv[i].jump;
      call = tv[i].call; ret = tv[i].ret; target = tv[i].tgt;
      tick();
      chk($sformatf("vec%0d", i), pack_main(),
          ep(0, 0, 1, tv[i].ev, tv[i].epc,
             tv[i].ezero ? 16'h0 : prog[tv[i].epc]));
    end
    clear_in();

    // Five nested calls overflow the 4-entry stack.
    call = 1; target = 20;
    for (int i = 0; i < 4; i++) tick();
    chk("call4", pack_main(), ep(0, 0, 1, 0, 5'd20, prog[20]));
    tick();
    chk("overflow", pack_main(), ep(1, 1, 0, 0, 5'd20, prog[20]));
    call = 0; jump = 1; target = 3;
    tick();
    chk("halt_hold", pack_main(), ep(1, 1, 0, 0, 5'd20, prog[20]));
    clear_in();

    do_reset("rst_halt");
    start = 1;
    tick();
    start = 0;
    chk("restart", pack_main(), ep(0, 0, 1, 0, 5'd0, 16'h0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("replay%0d", i), pack_main(),
          ep(0, 0, 1, 1, 5'(i), prog[i]));
    end
    do_reset("rst_run");

    start = 1;
    tick();
    start = 0;
    tick();
    ret = 1;
    tick();
    ret = 0;
    chk("underflow", pack_main(), ep(1, 1, 0, 0, 5'd0, prog[0]));
    do_reset("rst_err");

    // RAM writes during RUN and HALT must be dropped.
    start = 1;
    tick();
    start = 0;
    tick();
    prog_we = 1; waddr = 5; wdata = 16'hDEAD;
    for (int i = 1; i < 6; i++) begin
      tick();
      chk($sformatf("we_run%0d", i), pack_main(),
          ep(0, 0, 1, 1, 5'(i), prog[i]));
    end
    halt = 1;
    tick();
    halt = 0;
    chk("halt_req", pack_main(), ep(0, 1, 0, 0, 5'd5, prog[5]));
    tick();
    prog_we = 0;
    do_reset("rst_we");
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("ram_kept", pack_main(), ep(0, 0, 1, 1, 5'd5, prog[5]));

    // End of memory on the 3-bit instances.
    do_reset("rst_eom");
    for (int a = 0; a < 8; a++) begin
      prog_we = 1; waddr = 5'(a); wdata = eom[a];
      tick();
    end
    prog_we = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("nowrap%0d", i), {11'b0, s0_hlt, s0_v, s0_pc, s0_instr},
          {11'b0, (i == 7), 1'b1, 3'(i), eom[i]});
      chk($sformatf("wrap%0d", i), {11'b0, s1_hlt, s1_v, s1_pc, s1_instr},
          {11'b0, 1'b0, 1'b1, 3'(i), eom[i]});
    end
    tick();
    chk("nowrap_end", {11'b0, s0_hlt, s0_v, s0_pc, s0_instr},
        {11'b0, 1'b1, 1'b0, 3'd7, eom[7]});
    chk("wrap_end", {11'b0, s1_hlt, s1_v, s1_pc, s1_instr},
        {11'b0, 1'b0, 1'b1, 3'd0, eom[0]});

    // Randomized run against the reference model.
    rnd_reset();
    rnd_load();
    start = 1;
    rnd_tick();
    start = 0;
    hcnt = 0;
    for (int n = 0; n < 800; n++) begin
      ce = ($urandom_range(0, 5) != 0);
      halt = ($urandom_range(0, 299) == 0);
      jump = 0; call = 0; ret = 0;
      if (m_valid) begin
        r = $urandom_range(0, 19);
        ret  = (r <= 1) || (r == 5);
        call = (r == 2) || (r == 3) || (r == 5);
        jump = (r == 4);
      end
      target = 5'($urandom);
      prog_we = 1'($urandom); waddr = 5'($urandom); wdata = 16'($urandom);
      rnd_tick();
      if (m_mode == 2) hcnt++;
      if (hcnt > 2) begin
        rnd_reset();
        if ($urandom_range(0, 2) == 0) rnd_load();
        start = 1;
        rnd_tick();
        start = 0;
        hcnt = 0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
